// File: rtl/tribus_pkg.sv
// Shared types and elaboration helpers for the tristate-bus arbiter.
package tribus_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit params_legal(input int n, input int turn_cyc, input int max_hold);
    return (n >= 2) && (n <= 16) && (turn_cyc >= 1) && (max_hold >= 0);
  endfunction

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping mod N.
module rr_pick
  import tribus_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  // ptr_i is always < N, so a single conditional subtract is enough to wrap
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // Scan from the farthest slot down so the nearest hit is written last
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap(ptr_i, k)]) begin
        valid_o = 1'b1;
        idx_o   = wrap(ptr_i, k);
      end
    end
  end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin arbiter driving one-hot enables of shared tristate bus drivers,
// with a bounded hold time and a guaranteed all-off turnaround between owners.
module tribus_arbiter
  import tribus_pkg::*;
#(
  parameter int N        = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N-1:0]        REQ,
  output logic [N-1:0]        GNT,
  output logic [clog2(N)-1:0] OWNER,
  output logic                BUSY,
  output logic                PREEMPT
);

  localparam int OW = clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURN_CYC > 1) ? clog2(TURN_CYC) : 1;

  if (!params_legal(N, TURN_CYC, MAX_HOLD)) begin : g_bad_params
    $error("tribus_arbiter: illegal parameters (need 2<=N<=16, TURN_CYC>=1, MAX_HOLD>=0)");
  end

  state_e        state_q;
  logic [OW-1:0] ptr_q, ptr_d, owner_q, pick_idx;
  logic [HW-1:0] hold_q;
  logic [TW-1:0] turn_q;
  logic [N-1:0]  gnt_q, pick_oh;
  logic          busy_q, preempt_q;
  logic          pick_vld, arb_en, hold_max, release_now;

  rr_pick #(.N(N), .PW(OW)) u_pick (
    .req_i  (REQ),
    .ptr_i  (ptr_q),
    .valid_o(pick_vld),
    .idx_o  (pick_idx)
  );

  assign pick_oh     = {{(N-1){1'b0}}, 1'b1} << pick_idx;
  assign hold_max    = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));
  assign release_now = !REQ[owner_q] || hold_max;
  assign ptr_d       = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
  // IDLE and the final turnaround cycle share the same arbitration path
  assign arb_en      = (state_q == IDLE) || ((state_q == TURN) && (turn_q == '0));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      turn_q    <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        GRANT: begin
          if (release_now) begin
            state_q   <= TURN;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= ptr_d;
            hold_q    <= '0;
            turn_q    <= TW'(TURN_CYC - 1);
            // owner still asking means the hold limit forced it off
            preempt_q <= REQ[owner_q];
          end else if ((MAX_HOLD != 0) && !hold_max) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          if (!arb_en) begin
            turn_q <= turn_q - 1'b1;
          end else if (pick_vld) begin
            state_q <= GRANT;
            gnt_q   <= pick_oh;
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
            hold_q  <= HW'(1);
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign GNT     = gnt_q;
  assign OWNER   = owner_q;
  assign BUSY    = busy_q;
  assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: three parameter sets share one stimulus stream and
// are checked every cycle against a cycle-level behavioural model.
module tb_tribus_arbiter;
  import tribus_pkg::*;

  localparam int NCFG = 3;
  localparam int NA [NCFG] = '{4, 4, 5};
  localparam int TA [NCFG] = '{1, 2, 3};
  localparam int MA [NCFG] = '{4, 0, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;

  logic [15:0] gnt_a  [NCFG];
  logic [3:0]  own_a  [NCFG];
  logic        busy_a [NCFG];
  logic        pre_a  [NCFG];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int NN = NA[c];
    logic [NN-1:0]        gnt;
    logic [clog2(NN)-1:0] own;
    logic                 busy, pre;

    tribus_arbiter #(.N(NN), .TURN_CYC(TA[c]), .MAX_HOLD(MA[c])) u_dut (
      .CLK    (clk),
      .RST    (rst),
      .REQ    (req[NN-1:0]),
      .GNT    (gnt),
      .OWNER  (own),
      .BUSY   (busy),
      .PREEMPT(pre)
    );

    assign gnt_a[c]  = 16'(gnt);
    assign own_a[c]  = 4'(own);
    assign busy_a[c] = busy;
    assign pre_a[c]  = pre;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rr(input logic [15:0] r, input int p, input int n);
    for (int k = 0; k < n; k++)
      if (r[4'((p + k) % n)]) return (p + k) % n;
    return -1;
  endfunction

  // Model: owner (-1 = bus off), cycles held so far, remaining gap cycles, rr pointer
  int          m_own [NCFG], m_held [NCFG], m_gap [NCFG], m_ptr [NCFG];
  bit          m_pre [NCFG];
  bit          m_ok = 1'b0;
  int          zrun  [NCFG];
  bit          fresh [NCFG];
  logic [15:0] prev_g [NCFG];
  int          e_g, e_o, e_b, e_p, pick, cyc;

  initial begin : compare
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NCFG; c++) begin
        if (m_ok) begin
          e_g = (m_own[c] >= 0) ? (1 << m_own[c]) : 0;
          e_o = (m_own[c] >= 0) ? m_own[c] : 0;
          e_b = (m_own[c] >= 0) ? 1 : 0;
          e_p = m_pre[c] ? 1 : 0;
          checks++;
          if (gnt_a[c] != 16'(e_g) || own_a[c] != 4'(e_o) ||
              busy_a[c] != e_b[0] || pre_a[c] != e_p[0]) begin
            failures++;
            $display("FAIL model cfg%0d cyc%0d: got gnt=%h owner=%0d busy=%0d preempt=%0d expected gnt=%h owner=%0d busy=%0d preempt=%0d",
                     c, cyc, gnt_a[c], own_a[c], busy_a[c], pre_a[c], e_g, e_o, e_b, e_p);
          end
          checks++;
          if (!$onehot0(gnt_a[c]) || busy_a[c] != (gnt_a[c] != '0)) begin
            failures++;
            $display("FAIL onehot cfg%0d cyc%0d: got gnt=%h busy=%0d expected one-hot-or-zero with busy=|gnt",
                     c, cyc, gnt_a[c], busy_a[c]);
          end
          if (gnt_a[c] != '0) begin
            if (prev_g[c] == '0 && !fresh[c]) begin
              checks++;
              if (zrun[c] < TA[c]) begin
                failures++;
                $display("FAIL gap cfg%0d cyc%0d: got %0d zero cycles expected >= %0d", c, cyc, zrun[c], TA[c]);
              end
            end
            if (prev_g[c] != '0 && prev_g[c] != gnt_a[c]) begin
              checks++;
              failures++;
              $display("FAIL handover cfg%0d cyc%0d: got gnt %h -> %h expected a zero gap", c, cyc, prev_g[c], gnt_a[c]);
            end
            fresh[c] = 1'b0;
            zrun[c]  = 0;
          end else begin
            zrun[c]++;
          end
          prev_g[c] = gnt_a[c];
        end
        // advance the model to what the next edge must produce
        if (rst) begin
          m_own[c] = -1; m_ptr[c] = 0; m_held[c] = 0; m_gap[c] = 0; m_pre[c] = 1'b0;
          fresh[c] = 1'b1; prev_g[c] = '0; zrun[c] = 0;
        end else if (m_own[c] >= 0) begin
          if (!req[4'(m_own[c])] || (MA[c] != 0 && m_held[c] == MA[c])) begin
            m_pre[c]  = req[4'(m_own[c])];
            m_ptr[c]  = (m_own[c] + 1) % NA[c];
            m_own[c]  = -1;
            m_gap[c]  = TA[c];
            m_held[c] = 0;
          end else begin
            m_held[c]++;
            m_pre[c] = 1'b0;
          end
        end else begin
          m_pre[c] = 1'b0;
          if (m_gap[c] > 1) m_gap[c]--;
          else begin
            m_gap[c] = 0;
            pick = rr(req, m_ptr[c], NA[c]);
            if (pick >= 0) begin
              m_own[c]  = pick;
              m_held[c] = 1;
            end
          end
        end
      end
      if (rst) m_ok = 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int eg;
    rst = 1'b1;
    req = 16'hF;
    next_cycle();
    @(negedge clk);
    chk("reset gnt", int'(gnt_a[0]), 0);
    chk("reset busy", int'(busy_a[0]), 0);
    chk("reset owner", int'(own_a[0]), 0);
    chk("reset preempt", int'(pre_a[0]), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset gnt 2nd cycle", int'(gnt_a[0]), 0);
    next_cycle();
    @(negedge clk);
    chk("first grant after reset", int'(gnt_a[0]), 1);

    // saturation on cfg0 (MAX_HOLD=4, TURN_CYC=1): 4 grant cycles, 1 gap, rotate
    for (int i = 0; i < 20; i++) begin
      eg = (i % 5 == 4) ? 0 : (1 << ((i / 5) % 4));
      chk($sformatf("sat gnt i=%0d", i), int'(gnt_a[0]), eg);
      chk($sformatf("sat preempt i=%0d", i), int'(pre_a[0]), (i % 5 == 4) ? 1 : 0);
      @(negedge clk);
    end

    next_cycle();
    rst = 1'b1;
    req = '0;
    next_cycle();
    rst = 1'b0;

    // single request from requester 2
    for (int i = 0; i < 6; i++) begin
      req = (i < 3) ? 16'h4 : 16'h0;
      @(negedge clk);
      chk($sformatf("single gnt i=%0d", i), int'(gnt_a[0]), (i >= 1 && i <= 3) ? 4 : 0);
      chk($sformatf("single owner i=%0d", i), int'(own_a[0]), (i >= 1 && i <= 3) ? 2 : 0);
      chk($sformatf("single preempt i=%0d", i), int'(pre_a[0]), 0);
      next_cycle();
    end

    // fairness: owner 1 forced off with 1011 pending, pointer at 2 -> owner 3
    for (int i = 0; i < 7; i++) begin
      req = (i == 0) ? 16'h2 : 16'hB;
      @(negedge clk);
      eg = (i == 0 || i == 5) ? 0 : (i == 6) ? 8 : 2;
      chk($sformatf("fair gnt i=%0d", i), int'(gnt_a[0]), eg);
      chk($sformatf("fair preempt i=%0d", i), int'(pre_a[0]), (i == 5) ? 1 : 0);
      next_cycle();
    end

    repeat (3) begin
      req = '0;
      next_cycle();
    end

    // reset during owner 2's third grant cycle
    for (int i = 0; i < 6; i++) begin
      req = (i < 4) ? 16'h4 : 16'h5;
      rst = (i == 3);
      @(negedge clk);
      eg = (i >= 1 && i <= 3) ? 4 : (i == 5) ? 1 : 0;
      chk($sformatf("rstmid gnt i=%0d", i), int'(gnt_a[0]), eg);
      chk($sformatf("rstmid preempt i=%0d", i), int'(pre_a[0]), 0);
      next_cycle();
    end
    rst = 1'b0;

    // unlimited hold on cfg1 (MAX_HOLD=0, TURN_CYC=2)
    rst = 1'b1;
    req = '0;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i <= 104; i++) begin
      req = (i == 0) ? 16'h8 : (i <= 100) ? 16'h9 : 16'h1;
      @(negedge clk);
      eg = (i >= 1 && i <= 101) ? 8 : (i == 104) ? 1 : 0;
      chk($sformatf("unlim gnt i=%0d", i), int'(gnt_a[1]), eg);
      chk($sformatf("unlim preempt i=%0d", i), int'(pre_a[1]), 0);
      next_cycle();
    end

    // random traffic, mostly held requests with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0)
        req = ($urandom_range(0, 1) == 0) ? 16'($urandom()) : 16'($urandom() & $urandom());
      rst = ($urandom_range(0, 199) == 0);
      next_cycle();
    end
    rst = 1'b0;
    req = '0;
    repeat (6) next_cycle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tribus_arbiter.md
Name: tribus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared tristate bus built from enabled-inverter driver cells (ENINVX1/ENINVX2), one driver group per requester.
- Generates the one-hot driver enables, limits hold time per owner, and inserts a guaranteed all-off turnaround gap between owners so two drivers are never enabled together.
- Sits between the requesting blocks and the EN pins of the bus driver cells.

Parameters:
- N, 4, number of requesters/driver groups (2..16).
- TURN_CYC, 1, all-off cycles between successive owners (>=1).
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 = unlimited.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; synchronous, active-high.
- REQ  in  N  per-requester bus request, level, held while bus is wanted.
- GNT  out  N  one-hot grant; drives the driver-cell EN pins directly. All zero when the bus is idle.
- OWNER  out  clog2(N)  index of the current owner; valid when BUSY=1, else 0.
- BUSY  out  1  equals |GNT.
- PREEMPT  out  1  one-cycle pulse in the first TURN cycle after a MAX_HOLD-forced release.

Behaviour:
- All outputs are registered.
- Reset (RST=1 at an edge):
  - GNT=0, OWNER=0, BUSY=0, PREEMPT=0.
  - State=IDLE, rr pointer=0, hold counter=0.
  - Reset applies mid-grant too: GNT drops at the next edge, with no TURN sequence.
- IDLE:
  - Arbitrate on sampled REQ using round-robin: the first set bit at or after the pointer, wrapping modulo N.
  - If any REQ is set, go to GRANT at the edge, with GNT[i]=1, OWNER=i, counter=1.
  - Latency: REQ sampled in cycle k gives GNT in cycle k+1.
- GRANT (owner i):
  - Release when REQ[i]=0, or when MAX_HOLD!=0 and counter==MAX_HOLD.
  - On release: go to TURN at the edge, GNT=0, pointer=(i+1) mod N, TURN counter loaded.
  - PREEMPT=1 in the next cycle only if the release was forced by MAX_HOLD while REQ[i]=1.
  - Otherwise stay in GRANT and increment the counter, which saturates at MAX_HOLD.
  - REQ changes from non-owners are ignored during GRANT.
- TURN:
  - GNT=0 for exactly TURN_CYC cycles.
  - The last TURN cycle arbitrates as IDLE does: go to GRANT if any REQ is set, else IDLE. The inter-owner gap is therefore exactly TURN_CYC cycles.
  - A former owner re-requesting competes normally; the pointer has already advanced past it.
- Invariants:
  - GNT is zero or one-hot in every cycle.
  - Any change of a set bit in GNT is preceded by at least TURN_CYC all-zero cycles. The only exception is the first grant after reset, where RST itself provides the gap.
- Widths and boundaries:
  - Hold counter is clog2(MAX_HOLD+1) bits; pointer is clog2(N) bits and wraps N-1 -> 0.
  - When N is not a power of two, the pointer never takes values >= N.
  - Owner drops REQ in the same cycle the counter hits MAX_HOLD: this is a normal release, PREEMPT=0.

Decomposition:
- Shared package tribus_pkg:
  - State enum {IDLE, GRANT, TURN}.
  - clog2 helper function.
  - Parameter-legality checks (N>=2, TURN_CYC>=1).
- One combinational sub-module, rr_pick (REQ, pointer -> valid, index).
  - Reused by the IDLE and last-TURN arbitration paths.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ=4'b1111 -> GNT=0, BUSY=0, OWNER=0, PREEMPT=0 throughout; first grant to requester 0 in the cycle after RST falls.
- Single request: REQ[2]=1 in cycles 0-2, 0 from cycle 3 -> GNT=4'b0100 and OWNER=2 in cycles 1-3; GNT=0 from cycle 4; no PREEMPT.
- Saturation (N=4, MAX_HOLD=4, TURN_CYC=1, REQ=4'b1111 held) -> owners 0,1,2,3,0 each for 4 cycles, 1 all-zero cycle between; PREEMPT pulses in each gap cycle.
- Fairness: owner 1 releases while REQ=4'b1011 -> next GNT=4'b1000 (owner 3, not 0), after exactly TURN_CYC zero cycles.
- Reset mid-grant: RST=1 during owner 2's third grant cycle -> GNT=0 next cycle; after release, with REQ=4'b0101 -> owner 0 granted (pointer reset).
- Unlimited hold (MAX_HOLD=0): REQ[3] held 100 cycles while REQ[0] is also set -> GNT=4'b1000 continuously; PREEMPT never asserts; owner 0 granted TURN_CYC cycles after REQ[3] drops.
